fiber_access: RTL and testbench

- Sparse-tensor fiber storage block: a write scanner captures one compressed tile (coordinate stream) into a single-port SRAM as a segment array plus a coordinate array.
- A read scanner then serves upstream fiber positions, emitting each fiber's coordinates and their array positions as 17-bit token streams.
- Sits between GLB/stream producers and downstream SAM primitives; the external SRAM is driven through a plain memory port.

---
 rtl/fiber_access_pkg.sv | 62 ++++++
 rtl/fiber_read_scanner.sv | 166 ++++++++++++++++
 rtl/fiber_access.sv | 140 ++++++++++++++
 tb/tb_fiber_access.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fiber_access_pkg.sv
// fiber_access_pkg: shared widths, token encodings, memory map and token
// helpers for the fiber_access storage block.
//   Tokens are TOK_W bits. Bit 16 clear marks a data token with the payload
//   in [15:0]. Bit 16 set marks a control token: 0x1000n is stop Sn and
//   0x10100 is DONE.
package fiber_access_pkg;

   localparam int DATA_W     = 16;
   localparam int TOK_W      = DATA_W + 1;
   localparam int MEM_ADDR_W = 9;
   localparam int MEM_DATA_W = 64;

   localparam logic [MEM_ADDR_W-1:0] SEG_BASE = 9'd0;
   localparam logic [MEM_ADDR_W-1:0] CRD_BASE = 9'd256;

   localparam logic [TOK_W-1:0] STOP_TOK = 17'h10000;
   localparam logic [TOK_W-1:0] DONE_TOK = 17'h10100;

   typedef enum logic [0:0] {
      PH_WRITE,
      PH_READ
   } phase_t;

   typedef enum logic [2:0] {
      RS_IDLE,
      RS_SEG_LO,
      RS_SEG_HI,
      RS_EMIT,
      RS_LOAD,
      RS_PEEK,
      RS_TOKEN,
      RS_DONE_WAIT
   } rs_state_t;

   function automatic logic is_data(input logic [TOK_W-1:0] t);
      return !t[TOK_W-1];
   endfunction

   function automatic logic is_stop(input logic [TOK_W-1:0] t);
      return t[TOK_W-1] && (t[15:4] == 12'h000);
   endfunction

   function automatic logic is_done(input logic [TOK_W-1:0] t);
      return t == DONE_TOK;
   endfunction

   function automatic logic [3:0] stop_level(input logic [TOK_W-1:0] t);
      return t[3:0];
   endfunction

   // Stop one level above the given stop; S15 is the deepest level and
   // saturates there.
   function automatic logic [TOK_W-1:0] next_stop(input logic [TOK_W-1:0] t);
      logic [3:0]       lvl;
      logic [TOK_W-1:0] r;
      lvl    = stop_level(t);
      r      = STOP_TOK;
      r[3:0] = (lvl == 4'hF) ? 4'hF : lvl + 4'd1;
      return r;
   endfunction

endpackage

// File: rtl/fiber_read_scanner.sv
// fiber_read_scanner: read-phase FSM. For each upstream fiber position p
// it reads seg[p] and seg[p+1], then streams crd[seg[p]] .. crd[seg[p+1]-1]
// as coordinate tokens with their absolute crd index as position tokens,
// followed by the stop/DONE structure derived from the upstream stream.
//   clk, rst, en      : clock, sync reset, global advance enable
//   active            : tile is in the read phase
//   us_pos_in*        : upstream position stream (ready is raw, gated in top)
//   coord_* / pos_*   : paired output streams (valids raw, gated in top)
//   rd_addr, rd_en    : SRAM read request; rd_data is valid one cycle later
//   tile_done         : pulses once DONE has been accepted on both outputs
module fiber_read_scanner
   import fiber_access_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  active,
   input  logic [TOK_W-1:0]      us_pos_in,
   input  logic                  us_pos_in_valid,
   output logic                  us_pos_in_ready,
   output logic [TOK_W-1:0]      coord_out,
   output logic                  coord_out_valid,
   input  logic                  coord_out_ready,
   output logic [TOK_W-1:0]      pos_out,
   output logic                  pos_out_valid,
   input  logic                  pos_out_ready,
   output logic [MEM_ADDR_W-1:0] rd_addr,
   output logic                  rd_en,
   input  logic [DATA_W-1:0]     rd_data,
   output logic                  tile_done
);

   rs_state_t         state_q, state_d;
   logic              c_vld_q, p_vld_q;
   logic [TOK_W-1:0]  coord_q, pos_q;
   logic [7:0]        p_q;
   logic [TOK_W-1:0]  tok_q;
   logic [DATA_W-1:0] idx_q, hi_q;

   logic              slots_free;
   logic              load;
   logic [TOK_W-1:0]  load_tok, load_pos;

   assign slots_free      = !c_vld_q && !p_vld_q;
   assign coord_out       = coord_q;
   assign pos_out         = pos_q;
   assign coord_out_valid = c_vld_q;
   assign pos_out_valid   = p_vld_q;

   always_comb begin
      state_d         = state_q;
      us_pos_in_ready = 1'b0;
      rd_en           = 1'b0;
      rd_addr         = SEG_BASE;
      load            = 1'b0;
      load_tok        = '0;
      load_pos        = '0;
      tile_done       = 1'b0;
      case (state_q)
         RS_IDLE: begin
            us_pos_in_ready = active;
            if (active && us_pos_in_valid) begin
               if (is_data(us_pos_in)) begin
                  rd_en   = 1'b1;
                  rd_addr = SEG_BASE + {1'b0, us_pos_in[7:0]};
                  state_d = RS_SEG_LO;
               end else begin
                  state_d = RS_TOKEN;
               end
            end
         end
         RS_SEG_LO: begin
            rd_en   = 1'b1;
            rd_addr = SEG_BASE + {1'b0, p_q} + 9'd1;
            state_d = RS_SEG_HI;
         end
         RS_SEG_HI: state_d = RS_EMIT;
         RS_EMIT: begin
            if (idx_q >= hi_q) begin
               state_d = RS_PEEK;
            end else if (slots_free) begin
               // Only fetch once both output slots are empty, so the word
               // arriving next cycle always has a free place to land.
               rd_en   = 1'b1;
               rd_addr = CRD_BASE + {1'b0, idx_q[7:0]};
               state_d = RS_LOAD;
            end
         end
         RS_LOAD: begin
            load     = 1'b1;
            load_tok = {1'b0, rd_data};
            load_pos = {1'b0, idx_q};
            state_d  = RS_EMIT;
         end
         RS_PEEK: begin
            // Fiber finished: a stop upstream is absorbed and promoted one
            // level; data or DONE is left in place and closes with S0.
            if (slots_free && us_pos_in_valid) begin
               load = 1'b1;
               if (is_stop(us_pos_in)) begin
                  us_pos_in_ready = 1'b1;
                  load_tok        = next_stop(us_pos_in);
               end else begin
                  load_tok = STOP_TOK;
               end
               load_pos = load_tok;
               state_d  = RS_IDLE;
            end
         end
         RS_TOKEN: begin
            if (slots_free) begin
               load = 1'b1;
               if (is_done(tok_q)) begin
                  load_tok = DONE_TOK;
                  state_d  = RS_DONE_WAIT;
               end else begin
                  load_tok = next_stop(tok_q);
                  state_d  = RS_IDLE;
               end
               load_pos = load_tok;
            end
         end
         RS_DONE_WAIT: begin
            if (slots_free) begin
               tile_done = 1'b1;
               state_d   = RS_IDLE;
            end
         end
         default: state_d = RS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RS_IDLE;
         c_vld_q <= 1'b0;
         p_vld_q <= 1'b0;
      end else if (en) begin
         state_q <= state_d;
         if (c_vld_q && coord_out_ready) c_vld_q <= 1'b0;
         if (p_vld_q && pos_out_ready)   p_vld_q <= 1'b0;
         if (load) begin
            c_vld_q <= 1'b1;
            p_vld_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         if (load) begin
            coord_q <= load_tok;
            pos_q   <= load_pos;
         end
         if (state_q == RS_IDLE && us_pos_in_valid && us_pos_in_ready) begin
            p_q   <= us_pos_in[7:0];
            tok_q <= us_pos_in;
         end
         // seg[0] is always 0 and is never stored in the SRAM.
         if (state_q == RS_SEG_LO) idx_q <= (p_q == 8'd0) ? '0 : rd_data;
         if (state_q == RS_SEG_HI) hi_q  <= rd_data;
         if (state_q == RS_LOAD)   idx_q <= idx_q + 16'd1;
      end
   end

endmodule

// File: rtl/fiber_access.sv
// fiber_access: sparse-tensor fiber storage. In the write phase a
// compressed coordinate stream is captured into an external single-port
// SRAM as a segment array (SEG_BASE..) plus coordinate array (CRD_BASE..).
// After DONE the read scanner serves upstream fiber positions until it has
// emitted DONE, then the tile is freed for the next write.
//   clk, rst_n (active-high sync reset), clk_en, flush, tile_en
//   data_in*        : write coordinate stream
//   us_pos_in*      : upstream fiber positions
//   coord_out*      : coordinate tokens
//   pos_out*        : crd-array position tokens
//   *_to_mem, data_from_mem : SRAM port, 1-cycle read latency
module fiber_access
   import fiber_access_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clk_en,
   input  logic                  flush,
   input  logic                  tile_en,
   input  logic [TOK_W-1:0]      data_in,
   input  logic                  data_in_valid,
   output logic                  data_in_ready,
   input  logic [TOK_W-1:0]      us_pos_in,
   input  logic                  us_pos_in_valid,
   output logic                  us_pos_in_ready,
   output logic [TOK_W-1:0]      coord_out,
   output logic                  coord_out_valid,
   input  logic                  coord_out_ready,
   output logic [TOK_W-1:0]      pos_out,
   output logic                  pos_out_valid,
   input  logic                  pos_out_ready,
   output logic [MEM_ADDR_W-1:0] addr_to_mem,
   output logic [MEM_DATA_W-1:0] data_to_mem,
   output logic                  wen_to_mem,
   output logic                  ren_to_mem,
   input  logic [MEM_DATA_W-1:0] data_from_mem
);

   logic hold, go;
   // rst_n is active-high; flush has the same effect.
   assign hold = rst_n | flush;
   // Every handshake and state change is qualified by go, so clk_en=0 or
   // tile_en=0 freezes the block and hides all valids/readies.
   assign go   = clk_en & tile_en & ~hold;

   phase_t            phase;
   logic [8:0]        cnt;
   logic [7:0]        seg_cnt;
   logic              wr_pend;
   logic [MEM_ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic              in_acc;
   logic              sc_us_ready, sc_c_vld, sc_p_vld, sc_rd_en, tile_done;
   logic [MEM_ADDR_W-1:0] sc_rd_addr;
   logic              unused_mem_hi;

   assign unused_mem_hi = ^data_from_mem[MEM_DATA_W-1:DATA_W];

   // Write side accepts one token per write: while a write is pending the
   // port is busy, so ready drops for that cycle.
   assign data_in_ready = go && (phase == PH_WRITE) && !wr_pend;
   assign in_acc        = data_in_valid && data_in_ready;

   always_ff @(posedge clk) begin
      if (hold) begin
         phase   <= PH_WRITE;
         cnt     <= '0;
         seg_cnt <= '0;
         wr_pend <= 1'b0;
      end else if (go) begin
         if (wr_pend) wr_pend <= 1'b0;
         if (tile_done) begin
            phase   <= PH_WRITE;
            cnt     <= '0;
            seg_cnt <= '0;
         end
         if (in_acc) begin
            if (is_data(data_in)) begin
               // Past 256 coordinates the token is swallowed without a write.
               if (!cnt[8]) begin
                  wr_pend <= 1'b1;
                  cnt     <= cnt + 9'd1;
               end
            end else if (is_stop(data_in)) begin
               if (seg_cnt != 8'd255) begin
                  wr_pend <= 1'b1;
                  seg_cnt <= seg_cnt + 8'd1;
               end
            end else if (is_done(data_in)) begin
               phase <= PH_READ;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (go && in_acc) begin
         if (is_data(data_in)) begin
            wr_addr <= CRD_BASE + {1'b0, cnt[7:0]};
            wr_data <= data_in[DATA_W-1:0];
         end else begin
            wr_addr <= SEG_BASE + {1'b0, seg_cnt + 8'd1};
            wr_data <= {7'd0, cnt};
         end
      end
   end

   fiber_read_scanner u_scan (
      .clk             (clk),
      .rst             (hold),
      .en              (go),
      .active          (phase == PH_READ),
      .us_pos_in       (us_pos_in),
      .us_pos_in_valid (us_pos_in_valid),
      .us_pos_in_ready (sc_us_ready),
      .coord_out       (coord_out),
      .coord_out_valid (sc_c_vld),
      .coord_out_ready (coord_out_ready),
      .pos_out         (pos_out),
      .pos_out_valid   (sc_p_vld),
      .pos_out_ready   (pos_out_ready),
      .rd_addr         (sc_rd_addr),
      .rd_en           (sc_rd_en),
      .rd_data         (data_from_mem[DATA_W-1:0]),
      .tile_done       (tile_done)
   );

   assign us_pos_in_ready = sc_us_ready & go;
   assign coord_out_valid = sc_c_vld & go;
   assign pos_out_valid   = sc_p_vld & go;

   // Writes only happen in the write phase and reads only in the read
   // phase, so the two enables are exclusive by construction.
   assign wen_to_mem  = wr_pend & go;
   assign ren_to_mem  = sc_rd_en & go;
   assign addr_to_mem = wr_pend ? wr_addr : sc_rd_addr;
   assign data_to_mem = {{(MEM_DATA_W-DATA_W){1'b0}}, wr_data};

endmodule

// File: tb/tb_fiber_access.sv
// tb_fiber_access: directed and randomized bench for fiber_access with a
// behavioural SRAM and a token-list reference model.
module tb_fiber_access;

   localparam logic [16:0] S0   = 17'h10000;
   localparam logic [16:0] DONE = 17'h10100;

   logic        clk = 1'b0;
   logic        rst_n, clk_en, flush, tile_en;
   logic [16:0] data_in;
   logic        data_in_valid, data_in_ready;
   logic [16:0] us_pos_in;
   logic        us_pos_in_valid, us_pos_in_ready;
   logic [16:0] coord_out;
   logic        coord_out_valid, coord_out_ready;
   logic [16:0] pos_out;
   logic        pos_out_valid, pos_out_ready;
   logic [8:0]  addr_to_mem;
   logic [63:0] data_to_mem;
   logic        wen_to_mem, ren_to_mem;
   logic [63:0] data_from_mem;

   always #5 clk = ~clk;

   fiber_access dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .clk_en          (clk_en),
      .flush           (flush),
      .tile_en         (tile_en),
      .data_in         (data_in),
      .data_in_valid   (data_in_valid),
      .data_in_ready   (data_in_ready),
      .us_pos_in       (us_pos_in),
      .us_pos_in_valid (us_pos_in_valid),
      .us_pos_in_ready (us_pos_in_ready),
      .coord_out       (coord_out),
      .coord_out_valid (coord_out_valid),
      .coord_out_ready (coord_out_ready),
      .pos_out         (pos_out),
      .pos_out_valid   (pos_out_valid),
      .pos_out_ready   (pos_out_ready),
      .addr_to_mem     (addr_to_mem),
      .data_to_mem     (data_to_mem),
      .wen_to_mem      (wen_to_mem),
      .ren_to_mem      (ren_to_mem),
      .data_from_mem   (data_from_mem)
   );

   // Behavioural single-port SRAM, one-cycle read latency.
   logic [63:0] mem [0:511];
   always @(posedge clk) begin
      if (wen_to_mem) mem[addr_to_mem] <= data_to_mem;
      if (ren_to_mem) data_from_mem <= mem[addr_to_mem];
   end

   int ncmp = 0;
   int nfail = 0;
   int conflicts = 0;
   int wr_dones, cdone, pdone, out_dones;
   bit rnd;

   logic [16:0] wq[$], pq[$], ec[$], ep[$], tw[$], tp[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: rebuild the fibers from the write stream, then walk
   // the position stream and list every token each output must carry.
   task automatic add_tile();
      int crd[$];
      int seg[$];
      int i, p, lvl;
      logic [16:0] t, nxt, st;
      seg.push_back(0);
      foreach (tw[k]) begin
         wq.push_back(tw[k]);
         t = tw[k];
         if (!t[16]) crd.push_back(int'(t[15:0]));
         else if (t[15:4] == 12'h000) seg.push_back(crd.size());
      end
      foreach (tp[k]) pq.push_back(tp[k]);
      i = 0;
      while (i < tp.size()) begin
         t = tp[i];
         if (!t[16]) begin
            p = int'(t[15:0]);
            for (int j = seg[p]; j < seg[p+1]; j++) begin
               ec.push_back({1'b0, 16'(crd[j])});
               ep.push_back({1'b0, 16'(j)});
            end
            nxt = tp[i+1];
            if (nxt[16] && nxt != DONE) begin
               lvl = int'(nxt[3:0]) + 1;
               if (lvl > 15) lvl = 15;
               st = S0 | 17'(lvl);
               i++;
            end else begin
               st = S0;
            end
            ec.push_back(st);
            ep.push_back(st);
         end else if (t == DONE) begin
            ec.push_back(DONE);
            ep.push_back(DONE);
         end else begin
            lvl = int'(t[3:0]) + 1;
            if (lvl > 15) lvl = 15;
            ec.push_back(S0 | 17'(lvl));
            ep.push_back(S0 | 17'(lvl));
         end
         i++;
      end
   endtask

   task automatic clear_all();
      wq.delete(); pq.delete(); ec.delete(); ep.delete();
      wr_dones = 0; cdone = 0; pdone = 0; out_dones = 0;
   endtask

   task automatic quiet_inputs();
      @(negedge clk);
      data_in_valid   = 1'b0;
      us_pos_in_valid = 1'b0;
      coord_out_ready = 1'b1;
      pos_out_ready   = 1'b1;
      clk_en          = 1'b1;
   endtask

   task automatic run(input int budget, input bit abort_on_emit, output bit aborted);
      int cyc;
      cyc = 0;
      aborted = 1'b0;
      while ((wq.size() + pq.size() + ec.size() + ep.size()) != 0 && cyc < budget) begin
         @(negedge clk);
         clk_en          = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
         data_in_valid   = (wq.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
         data_in         = (wq.size() != 0) ? wq[0] : 17'h0;
         us_pos_in_valid = (pq.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
         us_pos_in       = (pq.size() != 0) ? pq[0] : 17'h0;
         coord_out_ready = !rnd || ($urandom_range(0, 2) != 0);
         pos_out_ready   = !rnd || ($urandom_range(0, 2) != 0);
         #1;
         if (abort_on_emit && coord_out_valid) begin
            coord_out_ready = 1'b0;
            pos_out_ready   = 1'b0;
            data_in_valid   = 1'b0;
            us_pos_in_valid = 1'b0;
            aborted = 1'b1;
            break;
         end
         if (wen_to_mem && ren_to_mem) conflicts++;
         if (data_in_valid && data_in_ready) begin
            chk("write_gate_tile", 32'(wr_dones), 32'(out_dones));
            if (wq[0] == DONE) wr_dones++;
            void'(wq.pop_front());
         end
         if (us_pos_in_valid && us_pos_in_ready) void'(pq.pop_front());
         if (coord_out_valid && coord_out_ready) begin
            if (ec.size() == 0) chk("coord_extra", 32'(ec.size()), 32'd1);
            else begin
               chk("coord_out", 32'(coord_out), 32'(ec[0]));
               if (ec[0] == DONE) cdone++;
               void'(ec.pop_front());
            end
         end
         if (pos_out_valid && pos_out_ready) begin
            if (ep.size() == 0) chk("pos_extra", 32'(ep.size()), 32'd1);
            else begin
               chk("pos_out", 32'(pos_out), 32'(ep[0]));
               if (ep[0] == DONE) pdone++;
               void'(ep.pop_front());
            end
         end
         out_dones = (cdone < pdone) ? cdone : pdone;
         cyc++;
      end
      if (!aborted)
         chk("tokens_left", 32'(wq.size() + pq.size() + ec.size() + ep.size()), 32'd0);
   endtask

   task automatic gen_random_tile();
      int nf, n, ng, np;
      tw.delete(); tp.delete();
      nf = int'($urandom_range(1, 5));
      for (int f = 0; f < nf; f++) begin
         n = int'($urandom_range(0, 3));
         for (int c = 0; c < n; c++) tw.push_back({1'b0, 16'($urandom)});
         tw.push_back(S0);
      end
      tw.push_back(DONE);
      ng = int'($urandom_range(1, 3));
      for (int g = 0; g < ng; g++) begin
         np = int'($urandom_range(1, 3));
         for (int q = 0; q < np; q++) tp.push_back({1'b0, 16'($urandom_range(0, nf - 1))});
         if (g < ng - 1) tp.push_back(S0 | 17'($urandom_range(0, 1)));
      end
      tp.push_back(DONE);
   endtask

   task automatic load_test1();
      tw = '{17'h00003, 17'h00007, 17'h10000, 17'h00001, 17'h10000, 17'h10100};
      tp = '{17'h00000, 17'h00001, 17'h10000, 17'h10100};
      add_tile();
   endtask

   initial begin
      bit ab;
      rst_n = 1'b1; flush = 1'b0; clk_en = 1'b1; tile_en = 1'b1;
      data_in = '0; data_in_valid = 1'b0;
      us_pos_in = '0; us_pos_in_valid = 1'b0;
      coord_out_ready = 1'b1; pos_out_ready = 1'b1;
      rnd = 1'b0;
      clear_all();

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_coord_valid", 32'(coord_out_valid), 32'd0);
      chk("rst_pos_valid", 32'(pos_out_valid), 32'd0);
      chk("rst_data_in_ready", 32'(data_in_ready), 32'd0);
      chk("rst_us_ready", 32'(us_pos_in_ready), 32'd0);
      chk("rst_wen", 32'(wen_to_mem), 32'd0);
      chk("rst_ren", 32'(ren_to_mem), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("write_phase_ready", 32'(data_in_ready), 32'd1);
      chk("write_phase_us_ready", 32'(us_pos_in_ready), 32'd0);
      tile_en = 1'b0;
      #1;
      chk("tile_dis_ready", 32'(data_in_ready), 32'd0);
      tile_en = 1'b1;

      // Two-fiber tile, free-flowing
      load_test1();
      run(2000, 1'b0, ab);
      quiet_inputs();

      // Same tile under random back-pressure and clock-enable gaps
      rnd = 1'b1;
      clear_all();
      load_test1();
      run(4000, 1'b0, ab);
      quiet_inputs();
      rnd = 1'b0;

      // Root read on single-fiber tile {5, 9}
      clear_all();
      tw = '{17'h00005, 17'h00009, 17'h10000, 17'h10100};
      tp = '{17'h00000, 17'h10100};
      add_tile();
      run(2000, 1'b0, ab);
      quiet_inputs();

      // Empty first fiber
      clear_all();
      tw = '{17'h10000, 17'h00004, 17'h10000, 17'h10100};
      tp = '{17'h00000, 17'h00001, 17'h10100};
      add_tile();
      run(2000, 1'b0, ab);
      quiet_inputs();

      // Back-to-back tiles queued at once
      rnd = 1'b1;
      clear_all();
      tw = '{17'h00005, 17'h00009, 17'h10000, 17'h10100};
      tp = '{17'h00000, 17'h10100};
      add_tile();
      load_test1();
      run(6000, 1'b0, ab);
      quiet_inputs();

      // Random tiles, pairs back-to-back
      for (int r = 0; r < 4; r++) begin
         clear_all();
         gen_random_tile();
         add_tile();
         gen_random_tile();
         add_tile();
         run(8000, 1'b0, ab);
         quiet_inputs();
      end
      rnd = 1'b0;

      // Reset while emitting, then a fresh tile
      clear_all();
      load_test1();
      run(2000, 1'b1, ab);
      chk("reached_emit", 32'(ab), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_coord_valid", 32'(coord_out_valid), 32'd0);
      chk("mid_rst_pos_valid", 32'(pos_out_valid), 32'd0);
      rst_n = 1'b0;
      coord_out_ready = 1'b1;
      pos_out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_coord_valid", 32'(coord_out_valid), 32'd0);
      chk("post_rst_write_ready", 32'(data_in_ready), 32'd1);
      clear_all();
      load_test1();
      run(2000, 1'b0, ab);
      quiet_inputs();

      chk("mem_wen_ren_overlap", 32'(conflicts), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
